// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm
// Miss/hit sequencer for one direct-mapped write-back cache. The tag and
// data arrays are external; this block only drives their write enables and
// the beat index used for line transfers to and from memory.
//
// Ports
//   clk, arstn       clock, asynchronous active-low reset
//   i_start_cache    request from main FSM (held while o_stall=1)
//   i_write_req      request is a store
//   i_hit            tag compare result (valid && tag match)
//   i_dirty          dirty bit of the indexed (victim) line
//   i_mem_ready      memory accepted the current write-back beat
//   i_mem_valid      memory returns a refill beat
//   o_stall          request not yet serviced
//   o_mem_rd_req     line refill request
//   o_mem_wr_req     victim write-back request
//   o_addr_sel       1 = victim address, 0 = request address
//   o_beat_idx       word index of the current memory beat
//   o_fill_we        write returned beat into data array
//   o_data_we        write CPU store word (store hit)
//   o_tag_we         write request tag
//   o_valid_set      set valid bit of indexed line
//   o_dirty_set      set dirty bit (store hit)
//   o_dirty_clr      clear dirty bit (refill complete)
module cache_ctrl_fsm #(
    parameter int BLOCK_WORDS = 16,
    parameter int CNT_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             i_start_cache,
    input  logic             i_write_req,
    input  logic             i_hit,
    input  logic             i_dirty,
    input  logic             i_mem_ready,
    input  logic             i_mem_valid,
    output logic             o_stall,
    output logic             o_mem_rd_req,
    output logic             o_mem_wr_req,
    output logic             o_addr_sel,
    output logic [CNT_W-1:0] o_beat_idx,
    output logic             o_fill_we,
    output logic             o_data_we,
    output logic             o_tag_we,
    output logic             o_valid_set,
    output logic             o_dirty_set,
    output logic             o_dirty_clr
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        ALLOCATE,
        REFILL_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_beat;

    assign last_beat = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_start_cache && !i_hit) begin
                    state_d = i_dirty ? WRITE_BACK : ALLOCATE;
                    cnt_d   = '0;
                end
            end
            WRITE_BACK: begin
                if (i_mem_ready) begin
                    if (last_beat) begin
                        state_d = ALLOCATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ALLOCATE: begin
                if (i_mem_valid) begin
                    if (last_beat) begin
                        state_d = REFILL_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REFILL_DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded combinationally: IDLE must answer a hit in the
    // same cycle and fills follow i_mem_valid directly. Qualifying with
    // arstn keeps every output low while reset is held, even though the
    // IDLE decode would otherwise react to a still-asserted request.
    always_comb begin
        o_stall      = 1'b0;
        o_mem_rd_req = 1'b0;
        o_mem_wr_req = 1'b0;
        o_addr_sel   = 1'b0;
        o_beat_idx   = '0;
        o_fill_we    = 1'b0;
        o_data_we    = 1'b0;
        o_tag_we     = 1'b0;
        o_valid_set  = 1'b0;
        o_dirty_set  = 1'b0;
        o_dirty_clr  = 1'b0;
        if (arstn) begin
            case (state_q)
                IDLE: begin
                    if (i_start_cache) begin
                        o_stall     = !i_hit;
                        o_data_we   = i_hit && i_write_req;
                        o_dirty_set = i_hit && i_write_req;
                    end
                end
                WRITE_BACK: begin
                    o_stall      = 1'b1;
                    o_mem_wr_req = 1'b1;
                    o_addr_sel   = 1'b1;
                    o_beat_idx   = cnt_q;
                end
                ALLOCATE: begin
                    o_stall      = 1'b1;
                    o_mem_rd_req = 1'b1;
                    o_beat_idx   = cnt_q;
                    o_fill_we    = i_mem_valid;
                end
                REFILL_DONE: begin
                    o_stall     = 1'b1;
                    o_tag_we    = 1'b1;
                    o_valid_set = 1'b1;
                    o_dirty_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm
// Transaction-level scoreboard bench for cache_ctrl_fsm. The stimulus side
// predicts the sequence of notable output events per request (write-back
// beats, fill beats, tag update, completion with stall count) and queues
// them; a monitor on the falling edge pops and compares each observed event.
module tb_cache_ctrl_fsm;

    localparam int BW   = 16;
    localparam int CW   = $clog2(BW);
    localparam int EW   = CW + 10;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          arstn;
    logic          i_start_cache, i_write_req, i_hit, i_dirty;
    logic          i_mem_ready, i_mem_valid;
    logic          o_stall, o_mem_rd_req, o_mem_wr_req, o_addr_sel;
    logic [CW-1:0] o_beat_idx;
    logic          o_fill_we, o_data_we, o_tag_we;
    logic          o_valid_set, o_dirty_set, o_dirty_clr;

    always #5 clk = ~clk;

    cache_ctrl_fsm #(.BLOCK_WORDS(BW), .CNT_W(CW)) dut (
        .clk(clk), .arstn(arstn),
        .i_start_cache(i_start_cache), .i_write_req(i_write_req),
        .i_hit(i_hit), .i_dirty(i_dirty),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid),
        .o_stall(o_stall), .o_mem_rd_req(o_mem_rd_req),
        .o_mem_wr_req(o_mem_wr_req), .o_addr_sel(o_addr_sel),
        .o_beat_idx(o_beat_idx), .o_fill_we(o_fill_we),
        .o_data_we(o_data_we), .o_tag_we(o_tag_we),
        .o_valid_set(o_valid_set), .o_dirty_set(o_dirty_set),
        .o_dirty_clr(o_dirty_clr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [EW-1:0] outs;
        int            stalls;   // -1: no stall-count check for this event
    } ev_t;

    ev_t exp_q[$];
    int  stall_run = 0;
    bit  rdy_a[MAXC];
    bit  vld_a[MAXC];

    function automatic logic [EW-1:0] mk(bit stall, bit rd, bit wr, bit sel,
                                         logic [CW-1:0] idx, bit fill, bit dwe,
                                         bit twe, bit vset, bit dset, bit dclr);
        return {stall, rd, wr, sel, idx, fill, dwe, twe, vset, dset, dclr};
    endfunction

    task automatic push(input logic [EW-1:0] o, input int s);
        ev_t e;
        e.outs   = o;
        e.stalls = s;
        exp_q.push_back(e);
    endtask

    // Handshake pattern per cycle of a transaction (cycle 0 = request cycle).
    task automatic gen(input int mode);
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0: begin rdy_a[i] = 1'b1; vld_a[i] = 1'b1; end
                1: begin
                    rdy_a[i] = ($urandom_range(0, 2) != 0);
                    vld_a[i] = ($urandom_range(0, 2) != 0);
                end
                2: begin rdy_a[i] = (i % 2 == 1); vld_a[i] = (i % 2 == 1); end
                default: begin rdy_a[i] = (((i - 1) % 4) != 1); vld_a[i] = 1'b1; end
            endcase
        end
    endtask

    // Stall cycles of a miss: request cycle, then as many cycles as it takes
    // to see BW ready pulses (dirty only), then BW valid pulses, then the
    // one-cycle tag update.
    function automatic int model_stalls(input bit dirty);
        int i = 1;
        int n = 0;
        if (dirty) begin
            while (n < BW && i < MAXC) begin
                if (rdy_a[i]) n++;
                i++;
            end
        end
        n = 0;
        while (n < BW && i < MAXC) begin
            if (vld_a[i]) n++;
            i++;
        end
        return i + 1;
    endfunction

    // Monitor
    always @(negedge clk) begin : mon
        ev_t           e;
        logic [EW-1:0] obs;
        bit            trig;
        if (!arstn) begin
            stall_run = 0;
        end else begin
            obs = mk(o_stall, o_mem_rd_req, o_mem_wr_req, o_addr_sel, o_beat_idx,
                     o_fill_we, o_data_we, o_tag_we, o_valid_set, o_dirty_set, o_dirty_clr);
            checks++;
            if ((o_mem_rd_req && o_mem_wr_req) || (o_fill_we && o_data_we)) begin
                errors++;
                $display("FAIL exclusive rd=%0b wr=%0b fill=%0b dwe=%0b required no pair high",
                         o_mem_rd_req, o_mem_wr_req, o_fill_we, o_data_we);
            end
            trig = (o_mem_wr_req && i_mem_ready) || o_fill_we || o_data_we || o_tag_we ||
                   o_valid_set || o_dirty_set || o_dirty_clr || (i_start_cache && !o_stall);
            if (i_start_cache && o_stall) stall_run++;
            if (trig) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got %h required none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e.outs) begin
                        errors++;
                        $display("FAIL event got %h required %h", obs, e.outs);
                    end
                    if (e.stalls >= 0) begin
                        checks++;
                        if (stall_run != e.stalls) begin
                            errors++;
                            $display("FAIL stall_count got %0d required %0d", stall_run, e.stalls);
                        end
                    end
                end
            end
            if (!i_start_cache || !o_stall) stall_run = 0;
        end
    end

    task automatic idle_cycles(input int n);
        i_start_cache = 1'b0;
        i_write_req   = 1'b0;
        i_hit         = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_mem_ready = 1'($urandom_range(0, 1));
            i_mem_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (o_stall || o_fill_we || o_mem_rd_req || o_mem_wr_req || o_beat_idx != '0) begin
                errors++;
                $display("FAIL idle_outputs stall=%0b fill=%0b rd=%0b wr=%0b idx=%0d required all 0",
                         o_stall, o_fill_we, o_mem_rd_req, o_mem_wr_req, o_beat_idx);
            end
            @(posedge clk); #1;
        end
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
    endtask

    // One request. drop_at >= 0 releases i_start_cache in that cycle of a miss.
    task automatic run_txn(input bit wr, input bit dirty, input bit hit0,
                           input int mode, input int drop_at);
        bit seen = 1'b0;
        bit done = 1'b0;
        gen(mode);
        if (hit0) begin
            push(mk(0, 0, 0, 0, '0, 0, wr, 0, 0, wr, 0), 0);
        end else begin
            if (dirty)
                for (int k = 0; k < BW; k++) push(mk(1, 0, 1, 1, CW'(k), 0, 0, 0, 0, 0, 0), -1);
            for (int k = 0; k < BW; k++) push(mk(1, 1, 0, 0, CW'(k), 1, 0, 0, 0, 0, 0), -1);
            push(mk(1, 0, 0, 0, '0, 0, 0, 1, 1, 0, 1), -1);
            if (drop_at < 0) push(mk(0, 0, 0, 0, '0, 0, wr, 0, 0, wr, 0), model_stalls(dirty));
        end
        i_start_cache = 1'b1;
        i_write_req   = wr;
        i_hit         = hit0;
        i_dirty       = dirty;
        for (int c = 0; c < MAXC && !done; c++) begin
            i_mem_ready = rdy_a[c];
            i_mem_valid = vld_a[c];
            if (drop_at >= 0 && c == drop_at) i_start_cache = 1'b0;
            @(negedge clk);
            if (i_start_cache && !o_stall) done = 1'b1;
            if (drop_at >= 0 && seen) done = 1'b1;
            if (o_valid_set) seen = 1'b1;
            @(posedge clk); #1;
            if (seen) begin
                i_hit   = 1'b1;
                i_dirty = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout got no completion required completion within %0d cycles", MAXC);
        end
        idle_cycles($urandom_range(1, 3));
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({o_stall, o_mem_rd_req, o_mem_wr_req, o_addr_sel, o_beat_idx, o_fill_we,
             o_data_we, o_tag_we, o_valid_set, o_dirty_set, o_dirty_clr} != '0) begin
            errors++;
            $display("FAIL %s got stall=%0b rd=%0b wr=%0b idx=%0d fill=%0b tag=%0b required all 0",
                     name, o_stall, o_mem_rd_req, o_mem_wr_req, o_beat_idx, o_fill_we, o_tag_we);
        end
    endtask

    // Clean miss with ideal memory, reset asynchronously after fill beat 7.
    task automatic reset_mid_allocate();
        bit hit7 = 1'b0;
        gen(0);
        for (int k = 0; k < 8; k++) push(mk(1, 1, 0, 0, CW'(k), 1, 0, 0, 0, 0, 0), -1);
        i_start_cache = 1'b1;
        i_write_req   = 1'b0;
        i_hit         = 1'b0;
        i_dirty       = 1'b0;
        i_mem_ready   = 1'b1;
        i_mem_valid   = 1'b1;
        for (int c = 0; c < 100 && !hit7; c++) begin
            @(negedge clk);
            if (o_fill_we && o_beat_idx == CW'(7)) hit7 = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!hit7) begin
            errors++;
            $display("FAIL reach_beat7 got no fill at idx 7 required one within 100 cycles");
        end
        #2 arstn = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        @(posedge clk); #1;
        check_all_zero("held_reset_outputs");
        arstn         = 1'b1;
        i_start_cache = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");
        @(posedge clk); #1;
        idle_cycles(2);
    endtask

    initial begin
        arstn         = 1'b0;
        i_start_cache = 1'b1;   // request pending during reset must stay masked
        i_write_req   = 1'b1;
        i_hit         = 1'b0;
        i_dirty       = 1'b1;
        i_mem_ready   = 1'b1;
        i_mem_valid   = 1'b1;
        #12 check_all_zero("reset_outputs");
        @(posedge clk); #1;
        arstn = 1'b1;
        idle_cycles(3);

        run_txn(1'b0, 1'b0, 1'b1, 0, -1);   // load hit
        run_txn(1'b1, 1'b0, 1'b1, 0, -1);   // store hit
        run_txn(1'b0, 1'b0, 1'b0, 2, -1);   // clean miss, valid every 2nd cycle
        run_txn(1'b1, 1'b1, 1'b0, 3, -1);   // dirty miss, ready 1,0,1,1,...
        run_txn(1'b0, 1'b0, 1'b0, 0, -1);   // clean miss, ideal memory
        run_txn(1'b1, 1'b1, 1'b0, 0, -1);   // dirty miss, ideal memory
        run_txn(1'b0, 1'b1, 1'b0, 1, 5);    // start dropped mid-miss
        reset_mid_allocate();
        run_txn(1'b0, 1'b0, 1'b1, 0, -1);   // hit right after reset
        run_txn(1'b1, 1'b0, 1'b0, 0, -1);   // miss right after reset

        for (int t = 0; t < 30; t++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : -1);
        end

        idle_cycles(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
